// File: rtl/arb_pkg.sv
// Shared definitions for the mux-based round-robin arbiter and its datapath mux.
package arb_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } occ_t;

   // Index arithmetic is done at this width before narrowing to the select width.
   typedef int unsigned sel_idx_t;

   function automatic int unsigned sel_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mux.sv
// Word-wide N:1 multiplexer; an out-of-range select yields zero.
module mux
   import arb_pkg::*;
#(
   parameter int unsigned NUM_INPUTS = 6,
   parameter int unsigned DATA_WIDTH = 8,
   localparam int unsigned SEL_W = sel_width(NUM_INPUTS)
) (
   input  logic [SEL_W-1:0]                 i_select,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data_bus,
   output logic [DATA_WIDTH-1:0]            o_data
);

   always_comb begin
      o_data = '0;
      for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
         if (i_select == SEL_W'(k)) begin
            o_data = i_data_bus[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a shared mux, with a valid/ready output register
// that can reload in the same cycle it drains.
module mux_rr_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned NUM_INPUTS = 6,
   parameter int unsigned DATA_WIDTH = 8,
   localparam int unsigned SEL_W = sel_width(NUM_INPUTS)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_INPUTS-1:0]            i_req,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data_bus,
   output logic [NUM_INPUTS-1:0]            o_ack,
   output logic [SEL_W-1:0]                 o_select,
   output logic                             o_valid,
   output logic [DATA_WIDTH-1:0]            o_data,
   output logic [SEL_W-1:0]                 o_grant_id,
   input  logic                             i_ready
);

   occ_t                  state, state_next;
   logic [SEL_W-1:0]      ptr;
   logic [SEL_W-1:0]      grant;
   logic [SEL_W-1:0]      idx;
   logic                  found;
   logic                  accept;
   sel_idx_t              sum;
   logic [DATA_WIDTH-1:0] mux_out;

   // Rotating priority search: first requester at or after ptr, wrapping.
   always_comb begin
      grant = '0;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
         sum = sel_idx_t'(ptr) + k;
         if (sum >= NUM_INPUTS) begin
            sum = sum - NUM_INPUTS;
         end
         idx = SEL_W'(sum);
         if (!found && i_req[idx]) begin
            grant = idx;
            found = 1'b1;
         end
      end
   end

   assign o_valid  = (state == FULL);
   assign accept   = !rst && (|i_req) && (!o_valid || i_ready);
   assign o_select = (|i_req) ? grant : ptr;

   always_comb begin
      o_ack = '0;
      if (accept) begin
         o_ack[grant] = 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   if (accept) state_next = FULL;
         FULL:    if (i_ready && !accept) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   mux #(
      .NUM_INPUTS (NUM_INPUTS),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mux (
      .i_select   (o_select),
      .i_data_bus (i_data_bus),
      .o_data     (mux_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= EMPTY;
         ptr        <= '0;
         o_data     <= '0;
         o_grant_id <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            o_data     <= mux_out;
            o_grant_id <= grant;
            ptr        <= (grant == SEL_W'(NUM_INPUTS - 1)) ? '0 : grant + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter (6 requesters, 8-bit words).
module tb_mux_rr_arbiter;

   localparam int unsigned N  = 6;
   localparam int unsigned DW = 8;
   localparam int unsigned SW = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      i_req;
   logic [N*DW-1:0]   i_data_bus;
   logic [N-1:0]      o_ack;
   logic [SW-1:0]     o_select;
   logic              o_valid;
   logic [DW-1:0]     o_data;
   logic [SW-1:0]     o_grant_id;
   logic              i_ready;

   int errors = 0;
   int checks = 0;

   mux_rr_arbiter #(
      .NUM_INPUTS (N),
      .DATA_WIDTH (DW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_req      (i_req),
      .i_data_bus (i_data_bus),
      .o_ack      (o_ack),
      .o_select   (o_select),
      .o_valid    (o_valid),
      .o_data     (o_data),
      .o_grant_id (o_grant_id),
      .i_ready    (i_ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      #2 rst = 1'b1;
      #1 rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      // load CC so that reset has something to clear
      i_req = 6'b001000; i_ready = 1'b1;
      tick();
      checks++;
      if (o_data !== 8'hCC) begin errors++; $display("FAIL reset_preload: got %h expected cc", o_data); end
      i_req = 6'b111111; i_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
      checks++;
      if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", o_data); end
      checks++;
      if (o_grant_id !== 3'd0) begin errors++; $display("FAIL reset_gid: got %0d expected 0", o_grant_id); end
      checks++;
      if (o_ack !== 6'b000000) begin errors++; $display("FAIL reset_ack: got %b expected 000000", o_ack); end
      #1 rst = 1'b0;
      #1;
      checks++;
      if (o_select !== 3'd0) begin errors++; $display("FAIL reset_ptr_select: got %0d expected 0", o_select); end
      checks++;
      if (o_ack !== 6'b000001) begin errors++; $display("FAIL reset_first_ack: got %b expected 000001", o_ack); end
      i_req = '0;
   endtask

   task automatic test_single();
      i_req = 6'b000100; i_ready = 1'b1;
      #1;
      checks++;
      if (o_ack !== 6'b000100) begin errors++; $display("FAIL single_ack: got %b expected 000100", o_ack); end
      checks++;
      if (o_select !== 3'd2) begin errors++; $display("FAIL single_select: got %0d expected 2", o_select); end
      tick();
      i_req = '0;
      checks++;
      if (o_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", o_valid); end
      checks++;
      if (o_data !== 8'hDD) begin errors++; $display("FAIL single_data: got %h expected dd", o_data); end
      checks++;
      if (o_grant_id !== 3'd2) begin errors++; $display("FAIL single_gid: got %0d expected 2", o_grant_id); end
   endtask

   task automatic test_all_requesting();
      logic [N-1:0]  exp_ack [7];
      logic [DW-1:0] exp_data [7];
      exp_ack  = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000, 6'b000001};
      exp_data = '{8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'hFF};
      pulse_reset();
      i_req = 6'b111111; i_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         #1;
         checks++;
         if (o_ack !== exp_ack[i]) begin errors++; $display("FAIL all_ack[%0d]: got %b expected %b", i, o_ack, exp_ack[i]); end
         tick();
         checks++;
         if (o_valid !== 1'b1 || o_data !== exp_data[i]) begin
            errors++; $display("FAIL all_data[%0d]: got v=%b %h expected v=1 %h", i, o_valid, o_data, exp_data[i]);
         end
      end
      i_req = '0;
   endtask

   task automatic test_backpressure();
      pulse_reset();
      i_req = 6'b000010; i_ready = 1'b1;
      tick();
      checks++;
      if (o_data !== 8'hEE) begin errors++; $display("FAIL bp_setup: got %h expected ee", o_data); end
      i_req = 6'b001001; i_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (o_ack !== 6'b000000) begin errors++; $display("FAIL bp_ack[%0d]: got %b expected 000000", i, o_ack); end
         checks++;
         if (o_select !== 3'd3) begin errors++; $display("FAIL bp_select[%0d]: got %0d expected 3", i, o_select); end
         tick();
         checks++;
         if (o_valid !== 1'b1 || o_data !== 8'hEE || o_grant_id !== 3'd1) begin
            errors++; $display("FAIL bp_hold[%0d]: got v=%b %h id=%0d expected v=1 ee id=1", i, o_valid, o_data, o_grant_id);
         end
      end
      i_ready = 1'b1;
      #1;
      checks++;
      if (o_ack !== 6'b001000) begin errors++; $display("FAIL bp_release_ack: got %b expected 001000", o_ack); end
      tick();
      i_req = '0;
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'hCC || o_grant_id !== 3'd3) begin
         errors++; $display("FAIL bp_release_data: got v=%b %h id=%0d expected v=1 cc id=3", o_valid, o_data, o_grant_id);
      end
   endtask

   task automatic test_wrap();
      // pointer is 4 here; grant 5 wraps it back to 0
      i_req = 6'b100000; i_ready = 1'b1;
      tick();
      checks++;
      if (o_grant_id !== 3'd5 || o_data !== 8'hAA) begin
         errors++; $display("FAIL wrap_g5: got id=%0d %h expected id=5 aa", o_grant_id, o_data);
      end
      i_req = 6'b100001;
      #1;
      checks++;
      if (o_ack !== 6'b000001) begin errors++; $display("FAIL wrap_ack0: got %b expected 000001", o_ack); end
      tick();
      checks++;
      if (o_grant_id !== 3'd0 || o_data !== 8'hFF) begin
         errors++; $display("FAIL wrap_g0: got id=%0d %h expected id=0 ff", o_grant_id, o_data);
      end
      #1;
      checks++;
      if (o_ack !== 6'b100000) begin errors++; $display("FAIL wrap_ack5: got %b expected 100000", o_ack); end
      tick();
      i_req = '0;
      checks++;
      if (o_grant_id !== 3'd5 || o_data !== 8'hAA) begin
         errors++; $display("FAIL wrap_g5b: got id=%0d %h expected id=5 aa", o_grant_id, o_data);
      end
   endtask

   task automatic test_idle_drain();
      i_req = '0; i_ready = 1'b1;
      #1;
      checks++;
      if (o_ack !== 6'b000000 || o_select !== 3'd0) begin
         errors++; $display("FAIL drain_comb: got ack=%b sel=%0d expected ack=000000 sel=0", o_ack, o_select);
      end
      tick();
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b expected 0", o_valid); end
      checks++;
      if (o_data !== 8'hAA || o_grant_id !== 3'd5) begin
         errors++; $display("FAIL drain_hold: got %h id=%0d expected aa id=5", o_data, o_grant_id);
      end
   endtask

   initial begin
      rst        = 1'b1;
      i_req      = '0;
      i_ready    = 1'b0;
      i_data_bus = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
      #12 rst = 1'b0;
      tick();
      test_reset();
      test_single();
      test_all_requesting();
      test_backpressure();
      test_wrap();
      test_idle_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
Round-robin arbiter that shares one mux-based datapath port between NUM_INPUTS requesters. It picks one requester per accepted transfer and drives the select of an internal `mux` instance. The selected word is captured in an output register with a valid/ready handshake. It sits between multiple producer stages (e.g. writeback sources) and a single consumer port of the processor.

Parameters:
NUM_INPUTS, 6, number of requesters / mux inputs (>=1)
DATA_WIDTH, 8, width of each requester's data word

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
i_req  input  NUM_INPUTS  per-requester request; bit k = requester k
i_data_bus  input  NUM_INPUTS*DATA_WIDTH  packed data; requester k at bits [k*DATA_WIDTH +: DATA_WIDTH]
o_ack  output  NUM_INPUTS  one-hot, combinational; requester k's word is taken this cycle
o_select  output  SEL_W  combinational select currently driven into the mux
o_valid  output  1  output register holds a word
o_data  output  DATA_WIDTH  registered selected word
o_grant_id  output  SEL_W  registered index of the requester that produced o_data
i_ready  input  1  consumer accepts o_data when o_valid & i_ready

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is asynchronous, active-high.
- SEL_W = max(1, $clog2(NUM_INPUTS)).
- Reset values, applied immediately on rst assertion independent of clk:
  - o_valid=0, o_data=0, o_grant_id=0, rotation pointer ptr=0.
  - o_ack is combinational: 0 whenever rst=1.
- accept = |i_req & (!o_valid | i_ready). This gives a pipeline-register slot: a new word may load in the same cycle the old one drains.
- Grant: the first set bit of i_req, searching indices ptr, ptr+1, …, NUM_INPUTS-1, 0, …, ptr-1.
- o_select = grant when |i_req, else ptr. It is always < NUM_INPUTS.
- o_ack = onehot(grant) when accept, else 0. At most one bit is set.
- On the clk edge when accept=1:
  - o_data <= mux output, i.e. slice grant of i_data_bus.
  - o_grant_id <= grant; o_valid <= 1.
  - ptr <= (grant==NUM_INPUTS-1) ? 0 : grant+1.
- On the edge when accept=0 and o_valid & i_ready: o_valid <= 0; o_data and o_grant_id hold.
- When o_valid & !i_ready: o_data, o_grant_id and ptr all hold; o_ack=0 (backpressure).
- Latency: request to o_valid is 1 cycle. Throughput is 1 word per cycle under continuous i_ready.
- Requester protocol:
  - A requester keeps i_req and its data slice stable until it sees its o_ack bit.
  - The arbiter does not store requests. Dropping i_req before ack is legal; that requester is simply not granted.
- Fairness: any continuously requesting input is granted within NUM_INPUTS accepts.
- NUM_INPUTS=1: grant is always 0 and ptr stays 0.
- Implicit state machine, derived from o_valid:
  - EMPTY (o_valid=0) -> FULL on accept.
  - FULL -> EMPTY on i_ready & !accept.
  - FULL -> FULL on a stall, or on i_ready & accept.

Decomposition:
- Shared package `arb_pkg`: function `sel_width(n)`, plus typedef for a select index used by the mux and this arbiter.
- Sub-module: the existing `mux` (NUM_INPUTS, DATA_WIDTH), instantiated once with i_select=o_select.
- Optional helper `rr_pick` containing the combinational rotate/priority-encode. It stays inside this file unless reused.

Test Plan:
- Reset: data_bus={AA,BB,CC,DD,EE,FF} (requester 0 = FF), rst pulsed asynchronously mid-cycle -> o_valid=0, o_data=00, o_grant_id=0 immediately; first grant afterwards starts search at 0.
- Single request: i_req=6'b000100, i_ready=1 -> same cycle o_ack=000100 and o_select=2; next cycle o_valid=1, o_data=DD, o_grant_id=2.
- All requesting: i_req=6'b111111 held, i_ready=1 for 7 cycles -> grants 0,1,2,3,4,5,0; o_data sequence FF,EE,DD,CC,BB,AA,FF with no bubbles.
- Backpressure:
  - Setup: o_valid=1 with o_data=EE, i_ready=0 for 3 cycles, i_req=6'b001001 -> o_ack=0, o_data=EE held, ptr unchanged.
  - Release: i_ready=1 -> the next grant follows ptr order, and o_data updates in the same handshake edge.
- Wrap-around: grant 5 issued, then i_req=6'b100001 -> grant 0 (ptr wrapped), then grant 5 on the following accept.
- Idle drain: o_valid=1, i_req=0, i_ready=1 -> o_valid=0 next cycle; o_data and o_grant_id retain their last values.
